// File: rtl/nibble_serial_sub32.sv
// nibble_serial_sub32
//   Multi-cycle subtractor: D = A - B - Bin, one DIGIT-bit nibble per clock,
//   LSB first, through a single nibble-wide borrow datapath.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   start in   request, sampled only while idle
//   A     in   minuend (latched on accepted start)
//   B     in   subtrahend (latched on accepted start)
//   Bin   in   borrow-in (latched on accepted start)
//   busy  out  high whenever not idle
//   done  out  one-cycle pulse, result valid
//   D     out  difference, held until the next accepted start
//   Bout  out  final borrow-out
//   Ovf   out  signed two's-complement overflow
//   Zero  out  D == 0
module nibble_serial_sub32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [WIDTH-1:0] d_q;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [DIGIT-1:0] a_nib;
    logic [DIGIT-1:0] b_nib;
    logic [DIGIT:0]   nib_full;
    logic             nib_borrow;
    logic [WIDTH-1:0] d_d;

    // One nibble of borrow datapath; the extra MSB of the widened
    // difference is the nibble's borrow-out.
    always_comb begin
        a_nib      = a_q[DIGIT*cnt_q +: DIGIT];
        b_nib      = b_q[DIGIT*cnt_q +: DIGIT];
        nib_full   = {1'b0, a_nib} - {1'b0, b_nib} - {{DIGIT{1'b0}}, borrow_q};
        nib_borrow = nib_full[DIGIT];
        d_d        = d_q;
        d_d[DIGIT*cnt_q +: DIGIT] = nib_full[DIGIT-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        cnt_q    <= '0;
                        d_q      <= '0;
                        bout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    d_q      <= d_d;
                    borrow_q <= nib_borrow;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Flags are taken from the final nibble's result (d_d),
                        // since d_q only picks it up at this same edge.
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        bout_q  <= nib_borrow;
                        ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (d_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q  <= (d_d == '0);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
    assign Ovf  = ovf_q;
    assign Zero = zero_q;

endmodule
